// File: rtl/rv_branch_redirect_pkg.sv
// Shared types and constants for the EX-stage branch redirect unit.
package rv_branch_redirect_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_type_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_REQ  = 1'b1
  } redir_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/rv_branch_target.sv
// Combinational branch/jump target, link value and misalignment detect.
module rv_branch_target
  import rv_branch_redirect_pkg::*;
#(
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  br_type_e    br_type,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] target,
  output logic [31:0] link_wdata,
  output logic        misaligned
);

  // JALR clears bit 0 of the sum; all other types are PC-relative.
  always_comb begin
    target = pc + imm;
    if (br_type == BR_JALR) begin
      target = (rs1 + imm) & ~32'h1;
    end
  end

  assign link_wdata = pc + PC_INC;
  assign misaligned = MISALIGN_CHK && target[1];

endmodule

// File: rtl/rv_branch_redirect.sv
// Branch resolution FSM: issues a registered redirect to IF and flushes until accepted.
module rv_branch_redirect
  import rv_branch_redirect_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  br_type_e         br_type,
  input  logic             cmp_res,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  output logic [31:0]      link_wdata,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             exc_valid,
  output logic [31:0]      exc_tval,
  output logic [CNT_W-1:0] taken_cnt
);

  redir_state_e state;
  logic [31:0]  target;
  logic         misaligned;
  logic         taken;
  logic         resolve;

  rv_branch_target #(
    .MISALIGN_CHK(MISALIGN_CHK)
  ) u_target (
    .br_type   (br_type),
    .pc        (pc),
    .imm       (imm),
    .rs1       (rs1),
    .target    (target),
    .link_wdata(link_wdata),
    .misaligned(misaligned)
  );

  assign taken = ex_valid && ((br_type == BR_JAL) || (br_type == BR_JALR) ||
                              ((br_type == BR_COND) && cmp_res));

  // Only an IDLE unit resolves; EX contents during REQ are wrong-path.
  assign resolve = (state == RD_IDLE) && taken;
  assign flush   = (state == RD_REQ) || (resolve && !misaligned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RD_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      exc_valid      <= 1'b0;
      exc_tval       <= 32'd0;
      taken_cnt      <= '0;
    end else begin
      exc_valid <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (resolve) begin
            if (misaligned) begin
              exc_valid <= 1'b1;
              exc_tval  <= target;
            end else begin
              state          <= RD_REQ;
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
            end
          end
        end
        RD_REQ: begin
          if (redirect_ready) begin
            state          <= RD_IDLE;
            redirect_valid <= 1'b0;
            taken_cnt      <= taken_cnt + CNT_W'(1);
          end
        end
        default: begin
          state          <= RD_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_branch_redirect.sv
// Self-checking bench: two DUT configurations driven in lockstep against a behavioural model.
module tb_rv_branch_redirect;
  import rv_branch_redirect_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  br_type_e    br_type;
  logic        cmp_res;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        redirect_ready;

  logic [31:0] link_w [2];
  logic        rv     [2];
  logic [31:0] rpc    [2];
  logic        fl     [2];
  logic        ev     [2];
  logic [31:0] tv     [2];
  logic [3:0]  cnt0;
  logic [31:0] cnt1;

  int total  = 0;
  int passed = 0;

  // Model state per instance: 0 = checked, 4-bit counter; 1 = unchecked, 32-bit counter
  bit          m_busy [2];
  logic [31:0] m_rpc  [2];
  logic [31:0] m_cnt  [2];
  bit          m_exc  [2];
  logic [31:0] m_tval [2];

  always #5 clk = ~clk;

  rv_branch_redirect #(.CNT_W(4), .MISALIGN_CHK(1'b1)) dut_chk (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .br_type(br_type),
    .cmp_res(cmp_res), .pc(pc), .imm(imm), .rs1(rs1),
    .link_wdata(link_w[0]), .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
    .redirect_ready(redirect_ready), .flush(fl[0]), .exc_valid(ev[0]),
    .exc_tval(tv[0]), .taken_cnt(cnt0)
  );

  rv_branch_redirect #(.CNT_W(32), .MISALIGN_CHK(1'b0)) dut_nochk (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .br_type(br_type),
    .cmp_res(cmp_res), .pc(pc), .imm(imm), .rs1(rs1),
    .link_wdata(link_w[1]), .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
    .redirect_ready(redirect_ready), .flush(fl[1]), .exc_valid(ev[1]),
    .exc_tval(tv[1]), .taken_cnt(cnt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] refTarget();
    logic [31:0] t;
    if (br_type == BR_JALR) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = pc + imm;
    end
    return t;
  endfunction

  function automatic bit refTaken();
    if (!ex_valid) return 1'b0;
    case (br_type)
      BR_JAL, BR_JALR: return 1'b1;
      BR_COND:         return cmp_res;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic bit refMis(input int k);
    logic [31:0] t;
    t = refTarget();
    return (k == 0) && (t[1] == 1'b1);
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_rpc[k]  = 32'd0;
      m_cnt[k]  = 32'd0;
      m_exc[k]  = 1'b0;
      m_tval[k] = 32'd0;
    end
  endfunction

  task automatic checkAll(input string ctx);
    logic [31:0] cnt_got;
    logic [31:0] cnt_exp;
    bit          exp_flush;
    for (int k = 0; k < 2; k++) begin
      exp_flush = m_busy[k] || (refTaken() && !refMis(k));
      cnt_got   = (k == 0) ? {28'd0, cnt0} : cnt1;
      cnt_exp   = (k == 0) ? (m_cnt[k] % 16) : m_cnt[k];
      checkOutput($sformatf("%s.flush%0d", ctx, k), {31'd0, fl[k]}, {31'd0, exp_flush});
      checkOutput($sformatf("%s.rvalid%0d", ctx, k), {31'd0, rv[k]}, {31'd0, m_busy[k]});
      if (m_busy[k]) checkOutput($sformatf("%s.rpc%0d", ctx, k), rpc[k], m_rpc[k]);
      checkOutput($sformatf("%s.exc%0d", ctx, k), {31'd0, ev[k]}, {31'd0, m_exc[k]});
      checkOutput($sformatf("%s.tval%0d", ctx, k), tv[k], m_tval[k]);
      checkOutput($sformatf("%s.link%0d", ctx, k), link_w[k], pc + 32'd4);
      checkOutput($sformatf("%s.cnt%0d", ctx, k), cnt_got, cnt_exp);
    end
  endtask

  function automatic void modelStep();
    logic [31:0] t;
    bit          tk;
    t  = refTarget();
    tk = refTaken();
    for (int k = 0; k < 2; k++) begin
      m_exc[k] = 1'b0;
      if (m_busy[k]) begin
        if (redirect_ready) begin
          m_busy[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 32'd1;
        end
      end else if (tk) begin
        if (refMis(k)) begin
          m_exc[k]  = 1'b1;
          m_tval[k] = t;
        end else begin
          m_busy[k] = 1'b1;
          m_rpc[k]  = t;
        end
      end
    end
  endfunction

  // Drives one cycle starting at a negedge; checks outputs, then advances the model at posedge.
  task automatic applyStimulus(input string ctx, input logic v, input br_type_e bt, input logic cr,
                               input logic [31:0] p, input logic [31:0] i, input logic [31:0] r1,
                               input logic rdy);
    ex_valid       = v;
    br_type        = bt;
    cmp_res        = cr;
    pc             = p;
    imm            = i;
    rs1            = r1;
    redirect_ready = rdy;
    #1;
    checkAll(ctx);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; br_type = BR_NONE; cmp_res = 1'b0;
    pc = 32'd0; imm = 32'd0; rs1 = 32'd0; redirect_ready = 1'b0;
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] conditional taken, ready immediately");
    applyStimulus("cond_n",  1'b1, BR_COND, 1'b1, 32'h100, 32'h20, 32'h0, 1'b1);
    checkOutput("cond.rpc_n1", rpc[0], 32'h120);
    applyStimulus("cond_n1", 1'b0, BR_NONE, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1);
    applyStimulus("cond_n2", 1'b0, BR_NONE, 1'b0, 32'h204, 32'h0, 32'h0, 1'b1);
    checkOutput("cond.cnt", cnt1, 32'd1);

    $display("[TB] conditional not taken");
    applyStimulus("ntk", 1'b1, BR_COND, 1'b0, 32'h100, 32'h20, 32'h0, 1'b1);
    applyStimulus("ntk1", 1'b1, BR_NONE, 1'b1, 32'h104, 32'h40, 32'h0, 1'b1);
    applyStimulus("ntk2", 1'b0, BR_NONE, 1'b0, 32'h108, 32'h0, 32'h0, 1'b1);

    $display("[TB] JALR with backpressure and wrong-path JAL");
    applyStimulus("jalr_n", 1'b1, BR_JALR, 1'b0, 32'h400, 32'h10, 32'h2001, 1'b0);
    checkOutput("jalr.link", link_w[0], 32'h404);
    for (int c = 0; c < 3; c++)
      applyStimulus("jalr_bp", 1'b1, BR_JAL, 1'b0, 32'h800, 32'h40, 32'h0, 1'b0);
    checkOutput("jalr.rpc_held", rpc[0], 32'h2010);
    applyStimulus("jalr_acc", 1'b1, BR_JAL, 1'b0, 32'h800, 32'h40, 32'h0, 1'b1);
    applyStimulus("jalr_done", 1'b0, BR_NONE, 1'b0, 32'h804, 32'h0, 32'h0, 1'b0);

    $display("[TB] misaligned JAL");
    applyStimulus("mis_n", 1'b1, BR_JAL, 1'b0, 32'h100, 32'h6, 32'h0, 1'b0);
    checkOutput("mis.tval", tv[0], 32'h106);
    checkOutput("mis.rpc_nochk", rpc[1], 32'h106);
    applyStimulus("mis_n1", 1'b0, BR_NONE, 1'b0, 32'h104, 32'h0, 32'h0, 1'b1);
    applyStimulus("mis_n2", 1'b0, BR_NONE, 1'b0, 32'h108, 32'h0, 32'h0, 1'b1);

    $display("[TB] reset during pending request");
    applyStimulus("mr_n", 1'b1, BR_JAL, 1'b0, 32'h100, 32'h20, 32'h0, 1'b0);
    applyStimulus("mr_req", 1'b0, BR_NONE, 1'b0, 32'h104, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("mr_async");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("mr_after", 1'b0, BR_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus("mr_after2", 1'b0, BR_NONE, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    $display("[TB] counter wrap");
    for (int j = 0; j < 16; j++) begin
      applyStimulus("wrap_res", 1'b1, BR_JAL, 1'b0, 32'h100, 32'h20, 32'h0, 1'b1);
      applyStimulus("wrap_acc", 1'b1, BR_JAL, 1'b0, 32'h100, 32'h20, 32'h0, 1'b1);
    end
    checkOutput("wrap.cnt0", {28'd0, cnt0}, 32'd0);
    checkOutput("wrap.cnt1", cnt1, 32'd16);

    $display("[TB] randomized traffic");
    for (int j = 0; j < 400; j++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 3) != 0),
                    br_type_e'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC,
                    $urandom & 32'h0000_0FFE,
                    $urandom,
                    1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
